// File: rtl/pipe_arith_pkg.sv
// Shared types and helpers for the sliced
// add/subtract/compare pipeline.
package pipe_arith_pkg;

  typedef struct packed {
    logic eq;
    logic gt;
  } cmp_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int MAX_CHUNK = 32;

  localparam cmp_t CMP_EQ = '{
    eq: 1'b1,
    gt: 1'b0
  };

  function automatic cmp_t slice_cmp(
    input logic [MAX_CHUNK-1:0] a,
    input logic [MAX_CHUNK-1:0] b
  );
    cmp_t c;
    c.eq = (a == b);
    c.gt = (a > b);
    return c;
  endfunction

endpackage

// File: rtl/pipe_addsub_cmp_if.sv
// Operand/result handshake bundle for
// the pipelined add/sub/compare unit.
interface pipe_addsub_cmp_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output in_valid,
    output a,
    output b,
    output op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  cout,
    input  eq,
    input  gt,
    input  lt
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output cout,
    output eq,
    output gt,
    output lt
  );

endinterface

// File: rtl/addsub_cmp_stage.sv
// One CHUNK-wide slice: add/sub with carry in,
// compare merge, and the stage output registers.
module addsub_cmp_stage
  import pipe_arith_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_i,
  input  logic             op_i,
  input  logic             cin_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  cmp_t             cmp_i,
  output logic             valid_o,
  output logic             cout_o,
  output logic [CHUNK-1:0] sum_o,
  output cmp_t             cmp_o
);

  logic [CHUNK-1:0] bb;
  logic [CHUNK:0]   tot;
  cmp_t             sc;
  cmp_t             cmp_d;

  always_comb begin
    bb = (op_i == OP_ADD) ? b_i : ~b_i;
    tot = {1'b0, a_i}
        + {1'b0, bb}
        + {{CHUNK{1'b0}}, cin_i};
    sc = slice_cmp(
      MAX_CHUNK'(a_i),
      MAX_CHUNK'(b_i)
    );
    // equal slice defers to lower slices
    cmp_d = sc.eq ? cmp_i : sc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      cout_o  <= 1'b0;
      sum_o   <= '0;
      cmp_o   <= '0;
    end else if (en) begin
      valid_o <= valid_i;
      cout_o  <= tot[CHUNK];
      sum_o   <= tot[CHUNK-1:0];
      cmp_o   <= cmp_d;
    end
  end

endmodule

// File: rtl/pipe_addsub_cmp.sv
// Pipelined add/sub with magnitude compare,
// one CHUNK slice per stage, LSB first.
module pipe_addsub_cmp
  import pipe_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic clk,
  input  logic rst,
  pipe_addsub_cmp_if.slave io
);

  localparam int STAGES = WIDTH / CHUNK;

  logic              adv;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] c_q;
  cmp_t              cmp_q [STAGES];
  logic [CHUNK-1:0]  s_q   [STAGES];

  assign adv = !v[STAGES-1] || io.out_ready;
  assign io.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - k*CHUNK;

    // operand bits still to be consumed,
    // current slice at the bottom
    logic [RW-1:0] ar;
    logic [RW-1:0] br;
    logic          vi;
    logic          opi;
    logic          ci;
    cmp_t          cmpi;

    if (k == 0) begin : g_in
      assign ar   = io.a;
      assign br   = io.b;
      assign vi   = io.in_valid;
      assign opi  = io.op;
      assign ci   = (io.op == OP_SUB);
      assign cmpi = CMP_EQ;
    end else begin : g_sk
      logic [k*CHUNK-1:0] lo;

      assign vi   = v[k-1];
      assign ci   = c_q[k-1];
      assign cmpi = cmp_q[k-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          ar  <= '0;
          br  <= '0;
          opi <= 1'b0;
        end else if (adv) begin
          ar  <= g_st[k-1].ar[RW+CHUNK-1:CHUNK];
          br  <= g_st[k-1].br[RW+CHUNK-1:CHUNK];
          opi <= g_st[k-1].opi;
        end
      end

      // finished low result slices
      if (k == 1) begin : g_l1
        always_ff @(posedge clk) begin
          if (rst) begin
            lo <= '0;
          end else if (adv) begin
            lo <= s_q[0];
          end
        end
      end else begin : g_ln
        always_ff @(posedge clk) begin
          if (rst) begin
            lo <= '0;
          end else if (adv) begin
            lo <= {s_q[k-1], g_st[k-1].g_sk.lo};
          end
        end
      end
    end

    addsub_cmp_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (adv),
      .valid_i (vi),
      .op_i    (opi),
      .cin_i   (ci),
      .a_i     (ar[CHUNK-1:0]),
      .b_i     (br[CHUNK-1:0]),
      .cmp_i   (cmpi),
      .valid_o (v[k]),
      .cout_o  (c_q[k]),
      .sum_o   (s_q[k]),
      .cmp_o   (cmp_q[k])
    );
  end

  if (STAGES == 1) begin : g_r1
    assign io.result = s_q[0];
  end else begin : g_rn
    assign io.result = {
      s_q[STAGES-1],
      g_st[STAGES-1].g_sk.lo
    };
  end

  assign io.out_valid = v[STAGES-1];
  assign io.cout      = c_q[STAGES-1];
  assign io.eq        = cmp_q[STAGES-1].eq;
  assign io.gt        = cmp_q[STAGES-1].gt;
  assign io.lt        = v[STAGES-1]
                      & !cmp_q[STAGES-1].eq
                      & !cmp_q[STAGES-1].gt;

endmodule

// File: tb/tb_pipe_addsub_cmp.sv
// Directed and scoreboarded checks for
// pipe_addsub_cmp at WIDTH=8, CHUNK=4.
module tb_pipe_addsub_cmp;

  localparam int NRAND = 10000;
  localparam int LIMIT = 6 * NRAND;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_addsub_cmp_if #(.WIDTH(8)) bus ();

  pipe_addsub_cmp #(
    .WIDTH (8),
    .CHUNK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_obs();
    return {19'd0, bus.out_valid, bus.result,
            bus.cout, bus.eq, bus.gt, bus.lt};
  endfunction

  function automatic logic [31:0] pk(
    input logic [7:0] res,
    input logic       c,
    input logic       e,
    input logic       g,
    input logic       l
  );
    return {19'd0, 1'b1, res, c, e, g, l};
  endfunction

  function automatic logic [12:0] model(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       op
  );
    logic [8:0] s;
    if (op) s = {1'b0, a} - {1'b0, b};
    else    s = {1'b0, a} + {1'b0, b};
    return {1'b1, s[7:0],
            op ? (a >= b) : s[8],
            a == b, a > b, a < b};
  endfunction

  task automatic drive(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       op
  );
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
  endtask

  task automatic one_beat(
    input string       tag,
    input logic [7:0]  a,
    input logic [7:0]  b,
    input logic        op,
    input logic [31:0] exp
  );
    drive(a, b, op);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk(tag, beat_obs(), exp);
    tick();
  endtask

  logic [31:0] sexp [4];
  logic [12:0] q [$];
  logic [31:0] e;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic        rop;
  logic        hold;
  int          sent;
  int          cyc;

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out", beat_obs(), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    chk("idle_out", beat_obs(), 32'd0);
    chk("idle_rdy", 32'(bus.in_ready), 32'd1);

    one_beat("add", 8'h3C, 8'h0F, 1'b0,
             pk(8'h4B, 0, 0, 1, 0));
    one_beat("wrap", 8'hFF, 8'h01, 1'b0,
             pk(8'h00, 1, 0, 1, 0));
    one_beat("sub", 8'h10, 8'h20, 1'b1,
             pk(8'hF0, 0, 0, 0, 1));
    one_beat("equal", 8'h5A, 8'h5A, 1'b1,
             pk(8'h00, 1, 1, 0, 0));
    one_beat("borrow", 8'h00, 8'h01, 1'b1,
             pk(8'hFF, 0, 0, 0, 1));

    // back-to-back stream at full rate
    sexp[0] = pk(8'h03, 0, 0, 0, 1);
    sexp[1] = pk(8'h00, 1, 0, 0, 0) | 32'h2;
    sexp[1] = pk(8'h00, 1, 1, 0, 0);
    sexp[2] = pk(8'h7E, 1, 0, 1, 0);
    sexp[3] = pk(8'hFF, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(8'h01, 8'h02, 1'b0);
        1: drive(8'h80, 8'h80, 1'b0);
        2: drive(8'h7F, 8'h01, 1'b1);
        3: drive(8'h00, 8'h01, 1'b1);
        default: bus.in_valid = 1'b0;
      endcase
      tick();
      if (i >= 1) chk("stream", beat_obs(), sexp[i-1]);
    end
    tick();
    chk("stream_end", 32'(bus.out_valid), 32'd0);

    // stall with a held input beat
    bus.out_ready = 1'b0;
    drive(8'h12, 8'h34, 1'b0);
    tick();
    drive(8'hC8, 8'h64, 1'b1);
    tick();
    chk("stall_first", beat_obs(),
        pk(8'h46, 0, 0, 0, 1));
    chk("stall_rdy0", 32'(bus.in_ready), 32'd0);
    drive(8'hAA, 8'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", beat_obs(),
          pk(8'h46, 0, 0, 0, 1));
      chk("stall_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("stall_second", beat_obs(),
        pk(8'h64, 1, 0, 1, 0));
    tick();
    chk("stall_held", beat_obs(),
        pk(8'hFF, 0, 0, 1, 0));
    tick();
    chk("stall_nodup", 32'(bus.out_valid), 32'd0);

    // reset with two beats in flight
    drive(8'h11, 8'h22, 1'b0);
    tick();
    drive(8'h33, 8'h44, 1'b0);
    tick();
    chk("pre_rst", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst", beat_obs(), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale", 32'(bus.out_valid), 32'd0);
    end

    // random traffic against a queue model
    sent = 0;
    cyc  = 0;
    hold = 1'b0;
    while ((sent < NRAND || q.size() != 0)
           && cyc < LIMIT) begin
      if (!hold) begin
        if (sent < NRAND &&
            $urandom_range(3) != 0) begin
          ra  = 8'($urandom);
          rb  = 8'($urandom);
          rop = 1'($urandom);
          drive(ra, rb, rop);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() != 0) e = {19'd0, q.pop_front()};
        else e = 32'hFFFF_FFFF;
        chk("rand", beat_obs(), e);
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.op));
        sent++;
        hold = 1'b0;
      end else begin
        hold = bus.in_valid;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("rand_sent", 32'(sent), 32'(NRAND));
    chk("rand_drain", 32'(q.size()), 32'd0);
    tick();
    chk("rand_idle", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
